// File: rtl/k10_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : k10_bus_arbiter
//  Purpose  : Shares the single K10 memory port between instruction fetch (IB)
//             and data (DB) requesters. One transaction in flight, issued from
//             a locked owner. Data has priority, with a starvation guard that
//             bounds how long fetch can be held off.
//  Revision : 1.0 - initial release
// ============================================================================
module k10_bus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    // instruction fetch requester
    input  logic                  i_ib_req,
    input  logic [ADDR_W-1:0]     i_ib_addr,
    input  logic                  i_ib_kill,
    output logic                  o_ib_gnt,
    output logic                  o_ib_rvalid,
    output logic [DATA_W-1:0]     o_ib_rdata,
    output logic                  o_ib_err,
    // data requester
    input  logic                  i_db_req,
    input  logic                  i_db_we,
    input  logic [DATA_W/8-1:0]   i_db_be,
    input  logic [ADDR_W-1:0]     i_db_addr,
    input  logic [DATA_W-1:0]     i_db_wdata,
    output logic                  o_db_gnt,
    output logic                  o_db_rvalid,
    output logic [DATA_W-1:0]     o_db_rdata,
    output logic                  o_db_err,
    // memory port
    output logic                  o_m_req,
    output logic                  o_m_we,
    output logic [DATA_W/8-1:0]   o_m_be,
    output logic [ADDR_W-1:0]     o_m_addr,
    output logic [DATA_W-1:0]     o_m_wdata,
    input  logic                  i_m_gnt,
    input  logic                  i_m_rvalid,
    input  logic [DATA_W-1:0]     i_m_rdata,
    input  logic                  i_m_err,
    // hazard-unit stalls
    output logic                  o_fetch_busy,
    output logic                  o_mem_busy
);

    localparam int BE_W   = DATA_W / 8;
    localparam int STRK_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [STRK_W-1:0] C_STREAK_MAX = STRK_W'(STARVE_LIMIT);
    localparam logic [STRK_W-1:0] C_STREAK_ONE = STRK_W'(1);
    localparam logic              C_OWN_IB     = 1'b0;
    localparam logic              C_OWN_DB     = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t              r_state_q,  w_state_d;
    logic                r_owner_q,  w_owner_d;
    logic                r_we_q,     w_we_d;
    logic [BE_W-1:0]     r_be_q,     w_be_d;
    logic [ADDR_W-1:0]   r_addr_q,   w_addr_d;
    logic [DATA_W-1:0]   r_wdata_q,  w_wdata_d;
    logic                r_kill_q,   w_kill_d;
    logic [STRK_W-1:0]   r_streak_q, w_streak_d;

    logic w_ib_win;
    logic w_db_win;
    logic w_rsp;

    // IB wins when DB is absent or when DB has starved it for STARVE_LIMIT wins
    assign w_ib_win = i_ib_req && (!i_db_req || (r_streak_q == C_STREAK_MAX));
    assign w_db_win = i_db_req && !w_ib_win;

    // State, owner, latched attributes, kill flag and starvation streak
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q  <= ST_IDLE;
            r_owner_q  <= C_OWN_IB;
            r_we_q     <= 1'b0;
            r_be_q     <= '0;
            r_addr_q   <= '0;
            r_wdata_q  <= '0;
            r_kill_q   <= 1'b0;
            r_streak_q <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_owner_q  <= w_owner_d;
            r_we_q     <= w_we_d;
            r_be_q     <= w_be_d;
            r_addr_q   <= w_addr_d;
            r_wdata_q  <= w_wdata_d;
            r_kill_q   <= w_kill_d;
            r_streak_q <= w_streak_d;
        end
    end

    // Next-state: arbitrate in IDLE, hold attributes through ISSUE/WAIT
    always_comb begin
        w_state_d  = r_state_q;
        w_owner_d  = r_owner_q;
        w_we_d     = r_we_q;
        w_be_d     = r_be_q;
        w_addr_d   = r_addr_q;
        w_wdata_d  = r_wdata_q;
        w_kill_d   = r_kill_q;
        w_streak_d = r_streak_q;

        case (r_state_q)
            ST_IDLE: begin
                w_kill_d = 1'b0;
                if (!i_ib_req) begin
                    w_streak_d = '0;
                end
                if (w_db_win) begin
                    w_state_d = ST_ISSUE;
                    w_owner_d = C_OWN_DB;
                    w_we_d    = i_db_we;
                    w_be_d    = i_db_be;
                    w_addr_d  = i_db_addr;
                    w_wdata_d = i_db_wdata;
                    if (i_ib_req && (r_streak_q != C_STREAK_MAX)) begin
                        w_streak_d = r_streak_q + C_STREAK_ONE;
                    end
                end else if (w_ib_win) begin
                    w_state_d  = ST_ISSUE;
                    w_owner_d  = C_OWN_IB;
                    w_we_d     = 1'b0;
                    w_be_d     = '1;
                    w_addr_d   = i_ib_addr;
                    w_wdata_d  = '0;
                    w_streak_d = '0;
                end
            end
            ST_ISSUE: begin
                if ((r_owner_q == C_OWN_IB) && i_ib_kill) begin
                    w_kill_d = 1'b1;
                end
                if (i_m_gnt) begin
                    w_state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if ((r_owner_q == C_OWN_IB) && i_ib_kill) begin
                    w_kill_d = 1'b1;
                end
                if (i_m_rvalid) begin
                    w_state_d = ST_IDLE;
                    w_kill_d  = 1'b0;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // Memory-side request and grant pulses back to the owner
    assign o_m_req   = (r_state_q == ST_ISSUE);
    assign o_m_we    = r_we_q;
    assign o_m_be    = r_be_q;
    assign o_m_addr  = r_addr_q;
    assign o_m_wdata = r_wdata_q;
    assign o_ib_gnt  = o_m_req && i_m_gnt && (r_owner_q == C_OWN_IB);
    assign o_db_gnt  = o_m_req && i_m_gnt && (r_owner_q == C_OWN_DB);

    // Responses count only in WAIT; stale rvalid in IDLE/ISSUE is dropped.
    // A kill arriving with the response suppresses it as well.
    assign w_rsp       = (r_state_q == ST_WAIT) && i_m_rvalid;
    assign o_ib_rvalid = w_rsp && (r_owner_q == C_OWN_IB) && !r_kill_q && !i_ib_kill;
    assign o_db_rvalid = w_rsp && (r_owner_q == C_OWN_DB);
    assign o_ib_rdata  = o_ib_rvalid ? i_m_rdata : '0;
    assign o_db_rdata  = o_db_rvalid ? i_m_rdata : '0;
    assign o_ib_err    = o_ib_rvalid && i_m_err;
    assign o_db_err    = o_db_rvalid && i_m_err;

    assign o_fetch_busy = i_ib_req && !o_ib_rvalid;
    assign o_mem_busy   = i_db_req && !o_db_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_k10_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_k10_bus_arbiter
//  Purpose  : Directed scoreboard bench for k10_bus_arbiter with a small
//             memory model (configurable grant/response delay and error).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_k10_bus_arbiter;

    localparam logic [31:0] C_XOR = 32'hDEADBFEF;

    typedef struct packed {
        logic        db;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ib_req, ib_kill, db_req, db_we;
    logic [31:0] ib_addr, db_addr, db_wdata;
    logic [3:0]  db_be;
    logic        ib_gnt, ib_rvalid, ib_err, db_gnt, db_rvalid, db_err;
    logic [31:0] ib_rdata, db_rdata;
    logic        m_req, m_we, m_gnt, m_rvalid, m_err;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        fetch_busy, mem_busy;

    int   n_vec = 0;
    int   n_err = 0;
    rsp_t exp_rsp[$];
    logic exp_gnt[$];

    // memory model configuration and state
    int          gnt_delay, rsp_delay, gcnt, rcnt;
    logic        err_cfg, rsp_pend;
    logic [31:0] rsp_addr;

    always #5 clk = ~clk;

    k10_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_ib_req(ib_req), .i_ib_addr(ib_addr), .i_ib_kill(ib_kill),
        .o_ib_gnt(ib_gnt), .o_ib_rvalid(ib_rvalid), .o_ib_rdata(ib_rdata), .o_ib_err(ib_err),
        .i_db_req(db_req), .i_db_we(db_we), .i_db_be(db_be), .i_db_addr(db_addr),
        .i_db_wdata(db_wdata),
        .o_db_gnt(db_gnt), .o_db_rvalid(db_rvalid), .o_db_rdata(db_rdata), .o_db_err(db_err),
        .o_m_req(m_req), .o_m_we(m_we), .o_m_be(m_be), .o_m_addr(m_addr), .o_m_wdata(m_wdata),
        .i_m_gnt(m_gnt), .i_m_rvalid(m_rvalid), .i_m_rdata(m_rdata), .i_m_err(m_err),
        .o_fetch_busy(fetch_busy), .o_mem_busy(mem_busy)
    );

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        return a ^ C_XOR;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mem(input int gd, input int rd, input logic e);
        gnt_delay = gd;
        rsp_delay = rd;
        gcnt      = gd;
        err_cfg   = e;
    endtask

    // which: 0 ib_rvalid, 1 db_rvalid, 2 ib_gnt, 3 db_gnt; returns at posedge+1
    task automatic wait_for(input int which, input string name);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            case (which)
                0: seen = ib_rvalid;
                1: seen = db_rvalid;
                2: seen = ib_gnt;
                default: seen = db_gnt;
            endcase
        end
        if (!seen) check({name, "_timeout"}, 64'd1, 64'd0);
        tick();
    endtask

    task automatic req_ib(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            ib_req  = 1'b1;
            ib_addr = base + 32'(4 * i);
            wait_for(0, "ib_rvalid");
        end
        ib_req = 1'b0;
    endtask

    task automatic req_db(input int n, input logic [31:0] base, input logic we,
                          input logic [3:0] be, input logic [31:0] wd);
        for (int i = 0; i < n; i++) begin
            db_req   = 1'b1;
            db_addr  = base + 32'(4 * i);
            db_we    = we;
            db_be    = be;
            db_wdata = wd;
            wait_for(1, "db_rvalid");
        end
        db_req = 1'b0;
    endtask

    // Memory model: grant after gnt_delay cycles of o_m_req, respond rsp_delay cycles later
    initial begin
        m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_err = 1'b0;
        rsp_pend = 1'b0; rcnt = 0; rsp_addr = '0;
        forever begin
            @(posedge clk);
            #1;
            m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_err = 1'b0;
            if (rsp_pend) begin
                if (rcnt == 0) begin
                    m_rvalid = 1'b1;
                    m_rdata  = rsp_addr ^ C_XOR;
                    m_err    = err_cfg;
                    rsp_pend = 1'b0;
                end else begin
                    rcnt--;
                end
            end
            if (m_req) begin
                if (gcnt == 0) begin
                    m_gnt    = 1'b1;
                    rsp_pend = 1'b1;
                    rcnt     = rsp_delay;
                    rsp_addr = m_addr;
                    gcnt     = gnt_delay;
                end else begin
                    gcnt--;
                end
            end
        end
    end

    // Monitor: pop expected grants/responses whenever the DUT presents one
    initial begin
        rsp_t e;
        logic g;
        forever begin
            @(negedge clk);
            if (ib_rvalid || db_rvalid) begin
                if (exp_rsp.size() == 0) begin
                    check("rsp_unexpected", {62'd0, ib_rvalid, db_rvalid}, 64'd0);
                end else begin
                    e = exp_rsp.pop_front();
                    check("rsp_owner", {62'd0, ib_rvalid, db_rvalid}, e.db ? 64'd1 : 64'd2);
                    check("rsp_data", db_rvalid ? db_rdata : ib_rdata, e.data);
                    check("rsp_err", db_rvalid ? db_err : ib_err, e.err);
                end
            end
            if (ib_gnt || db_gnt) begin
                if (exp_gnt.size() == 0) begin
                    check("gnt_unexpected", {62'd0, ib_gnt, db_gnt}, 64'd0);
                end else begin
                    g = exp_gnt.pop_front();
                    check("gnt_owner", {62'd0, ib_gnt, db_gnt}, g ? 64'd1 : 64'd2);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        int issue_cycles, gnt_count;
        rst = 1'b1; ib_req = 1'b0; ib_kill = 1'b0; ib_addr = '0;
        db_req = 1'b0; db_we = 1'b0; db_be = '0; db_addr = '0; db_wdata = '0;
        set_mem(0, 0, 1'b0);
        repeat (3) tick();
        @(negedge clk);
        check("reset_m_req", m_req, 0);
        check("reset_m_attr", {m_we, m_be, m_addr, m_wdata}, 0);
        check("reset_rsp", {ib_rvalid, db_rvalid, ib_gnt, db_gnt}, 0);
        tick();
        rst = 1'b0;
        tick();

        // Lone IB fetch, zero-wait memory
        exp_gnt.push_back(1'b0);
        exp_rsp.push_back('{db: 1'b0, data: 32'hDEADBEEF, err: 1'b0});
        ib_req = 1'b1; ib_addr = 32'h100;
        @(negedge clk);
        check("c0_fetch_busy", fetch_busy, 1);
        check("c0_m_req", m_req, 0);
        @(negedge clk);
        check("c1_m_req", m_req, 1);
        check("c1_m_attr", {m_we, m_be, m_addr, m_wdata}, {1'b0, 4'hF, 32'h100, 32'h0});
        check("c1_fetch_busy", fetch_busy, 1);
        @(negedge clk);
        check("c2_ib_rvalid", ib_rvalid, 1);
        check("c2_fetch_busy", fetch_busy, 0);
        tick();
        ib_req = 1'b0;
        tick();

        // Starvation guard: DB x4, IB, DB x4, IB
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                exp_gnt.push_back(1'b0);
                exp_rsp.push_back('{db: 1'b0, data: exp_rd(32'h100), err: 1'b0});
            end else if (i == 9) begin
                exp_gnt.push_back(1'b0);
                exp_rsp.push_back('{db: 1'b0, data: exp_rd(32'h104), err: 1'b0});
            end else begin
                exp_gnt.push_back(1'b1);
                exp_rsp.push_back('{db: 1'b1,
                    data: exp_rd(32'h200 + 32'(4 * (i < 4 ? i : i - 1))), err: 1'b0});
            end
        end
        fork
            req_ib(2, 32'h100);
            req_db(8, 32'h200, 1'b0, 4'hF, 32'h0);
        join
        tick();

        // Store with grant delayed 3 cycles
        set_mem(3, 0, 1'b0);
        exp_gnt.push_back(1'b1);
        exp_rsp.push_back('{db: 1'b1, data: exp_rd(32'h300), err: 1'b0});
        issue_cycles = 0; gnt_count = 0;
        fork
            req_db(1, 32'h300, 1'b1, 4'b0011, 32'h1234);
            begin
                for (int c = 0; c < 8; c++) begin
                    @(negedge clk);
                    if (m_req) begin
                        issue_cycles++;
                        check("store_m_attr", {m_we, m_be, m_addr, m_wdata},
                              {1'b1, 4'b0011, 32'h300, 32'h1234});
                    end
                    if (db_gnt) gnt_count++;
                end
            end
        join
        check("store_issue_cycles", issue_cycles, 4);
        check("store_gnt_pulses", gnt_count, 1);
        tick();

        // Kill in WAIT: response 2 cycles later is suppressed, DB then issues normally
        set_mem(0, 2, 1'b0);
        exp_gnt.push_back(1'b0);
        ib_req = 1'b1; ib_addr = 32'h140;
        wait_for(2, "ib_gnt");
        ib_kill = 1'b1; ib_req = 1'b0;
        tick();
        ib_kill = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("kill_ib_rvalid", ib_rvalid, 0);
        end
        tick();
        exp_gnt.push_back(1'b1);
        exp_rsp.push_back('{db: 1'b1, data: exp_rd(32'h500), err: 1'b0});
        req_db(1, 32'h500, 1'b0, 4'hF, 32'h0);
        tick();

        // Bus error on DB with kill held (no effect in IDLE or on DB owner)
        set_mem(0, 0, 1'b1);
        exp_gnt.push_back(1'b1);
        exp_rsp.push_back('{db: 1'b1, data: exp_rd(32'h400), err: 1'b1});
        ib_kill = 1'b1;
        fork
            req_db(1, 32'h400, 1'b0, 4'hF, 32'h0);
            begin
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    check("err_ib_quiet", {ib_rvalid, ib_err, ib_gnt}, 0);
                end
            end
        join
        ib_kill = 1'b0;
        tick();

        // Reset in WAIT followed by a stale response
        set_mem(0, 3, 1'b0);
        exp_gnt.push_back(1'b0);
        ib_req = 1'b1; ib_addr = 32'h180;
        wait_for(2, "ib_gnt");
        rst = 1'b1; ib_req = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_m_out", {m_req, m_we, m_be, m_addr, m_wdata}, 0);
        check("rst_rsp_out", {ib_rvalid, db_rvalid, ib_err, db_err, ib_gnt, db_gnt}, 0);
        check("rst_busy", {fetch_busy, mem_busy}, 0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("stale_quiet", {m_req, ib_rvalid, db_rvalid}, 0);
        end

        repeat (3) tick();
        check("rsp_queue_empty", exp_rsp.size(), 0);
        check("gnt_queue_empty", exp_gnt.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
